sonar_echo_emulator: RTL and testbench

- Synthesizable stand-in for the HC-SR04 ultrasonic module: responds to a trigger pulse with an echo pulse whose width encodes a programmed distance.
- Drives the sonar ranging block's echo input in simulation and in hardware-in-loop builds, where a spare GPIO pin is looped to the ranger.
- Runs on the 43.904 MHz sonar clock, where one mm of distance equals exactly 256 cycles of round-trip echo time.

---
 rtl/sonar_echo_emulator.sv | 170 +++++++++++++++++
 tb/tb_sonar_echo_emulator.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sonar_echo_emulator.sv
// HC-SR04 stand-in: answers a trigger pulse with an echo whose width encodes distance_mm.
// Optional echo-width jitter from an 8-bit LFSR when SONAR_EMU_JITTER_EN is defined.
module sonar_echo_emulator #(
    parameter int CYCLES_PER_MM = 256,
    parameter int MIN_TRIG_CYC  = 440,
    parameter int BURST_CYC     = 8780,
    parameter int MAX_MM        = 4000,
    parameter int TIMEOUT_CYC   = 1668352,
    parameter int HOLDOFF_CYC   = 10000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        trig,
    input  logic [11:0] distance_mm,
    output logic        echo,
    output logic        busy,
    output logic        trig_err
);

    localparam int CW = 22;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        TRIG_HIGH = 3'd1,
        BURST     = 3'd2,
        ECHO      = 3'd3,
        HOLDOFF   = 3'd4
    } state_t;

    state_t          state_q, state_d;
    logic            trig_m, trig_s, trig_prev;
    logic            rise, fall;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [CW-1:0]   echo_w;
    logic [11:0]     dist_q;
    logic            latch;
    logic            echo_d, err_d;
    logic            dist_valid;

    always_ff @(posedge clk) begin
        if (rst) begin
            trig_m    <= 1'b0;
            trig_s    <= 1'b0;
            trig_prev <= 1'b0;
        end else begin
            trig_m    <= trig;
            trig_s    <= trig_m;
            trig_prev <= trig_s;
        end
    end

    assign rise = trig_s & ~trig_prev;
    assign fall = ~trig_s & trig_prev;

    assign dist_valid = (dist_q != 12'd0) && (CW'(dist_q) <= CW'(MAX_MM));

`ifdef SONAR_EMU_JITTER_EN
    logic [7:0] lfsr_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            lfsr_q <= 8'hA5;
        end else if (latch) begin
            lfsr_q <= {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
        end
    end

    // lfsr_q already holds the post-advance value by the time BURST reads it.
    always_comb begin
        if (dist_valid) begin
            echo_w = CW'(dist_q) * CW'(CYCLES_PER_MM) + CW'(lfsr_q);
        end else begin
            echo_w = CW'(TIMEOUT_CYC);
        end
    end
`else
    always_comb begin
        if (dist_valid) begin
            echo_w = CW'(dist_q) * CW'(CYCLES_PER_MM);
        end else begin
            echo_w = CW'(TIMEOUT_CYC);
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            dist_q   <= '0;
            echo     <= 1'b0;
            trig_err <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            echo     <= echo_d;
            trig_err <= err_d;
            if (latch) begin
                dist_q <= distance_mm;
            end
        end
    end

    // cnt is shared: trigger width up-count, burst up-count, echo/holdoff down-count.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        echo_d  = echo;
        err_d   = 1'b0;
        latch   = 1'b0;
        case (state_q)
            IDLE: begin
                if (rise) begin
                    state_d = TRIG_HIGH;
                    cnt_d   = CW'(1);
                end
            end
            TRIG_HIGH: begin
                if (fall) begin
                    cnt_d = '0;
                    if (cnt_q >= CW'(MIN_TRIG_CYC)) begin
                        latch   = 1'b1;
                        state_d = BURST;
                    end else begin
                        err_d   = 1'b1;
                        state_d = IDLE;
                    end
                end else if (trig_s && (cnt_q < CW'(MIN_TRIG_CYC))) begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            BURST: begin
                if ((cnt_q + CW'(1)) >= CW'(BURST_CYC)) begin
                    state_d = ECHO;
                    echo_d  = 1'b1;
                    cnt_d   = echo_w;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            ECHO: begin
                if (cnt_q <= CW'(1)) begin
                    state_d = HOLDOFF;
                    echo_d  = 1'b0;
                    cnt_d   = CW'(HOLDOFF_CYC);
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            HOLDOFF: begin
                if (cnt_q <= CW'(1)) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
                echo_d  = 1'b0;
            end
        endcase
    end

    always_comb begin
        busy = (state_q != IDLE);
    end

endmodule

// File: tb/tb_sonar_echo_emulator.sv
// Randomized scoreboard bench for sonar_echo_emulator with small timing parameters.
module tb_sonar_echo_emulator;

    localparam int CPM     = 4;
    localparam int MIN_TRG = 8;
    localparam int BURST   = 16;
    localparam int MAXMM   = 100;
    localparam int TMO     = 1000;
    localparam int HOLD    = 20;

    logic        clk = 1'b0;
    logic        rst;
    logic        trig;
    logic [11:0] distance;
    logic        echo;
    logic        busy;
    logic        trig_err;

    sonar_echo_emulator #(
        .CYCLES_PER_MM (CPM),
        .MIN_TRIG_CYC  (MIN_TRG),
        .BURST_CYC     (BURST),
        .MAX_MM        (MAXMM),
        .TIMEOUT_CYC   (TMO),
        .HOLDOFF_CYC   (HOLD)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .trig        (trig),
        .distance_mm (distance),
        .echo        (echo),
        .busy        (busy),
        .trig_err    (trig_err)
    );

    // clock / cycle counter
    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #(10 * 200000);
        $display("FAIL watchdog: got no finish, required finish within 200000 cycles");
        $fatal(1, "watchdog");
    end

    // scoreboard state
    logic [31:0] exp_w_q[$];
    logic [31:0] exp_r_q[$];
    logic [31:0] exp_err_q[$];
    logic [31:0] exp_busy_q[$];
    int          n_checks = 0;
    int          n_pass   = 0;
    logic [7:0]  lfsr_m;

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    endtask

    function automatic logic [7:0] lfsr_step(input logic [7:0] v);
        return {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
    endfunction

    function automatic int model_width(input int d, input logic [7:0] jit);
        int w;
        if (d == 0 || d > MAXMM) return TMO;
        w = d * CPM;
`ifdef SONAR_EMU_JITTER_EN
        w = w + int'(jit);
`endif
        return w;
    endfunction

    // monitor
    logic        in_pulse  = 1'b0;
    logic        busy_prev = 1'b0;
    int unsigned rise_c    = 0;

    initial begin
        forever begin
            @(negedge clk);
            if (rst) begin
                in_pulse  = 1'b0;
                busy_prev = busy;
                exp_w_q.delete();
                exp_r_q.delete();
                exp_err_q.delete();
                exp_busy_q.delete();
                continue;
            end
            if (echo && !in_pulse) begin
                in_pulse = 1'b1;
                rise_c   = cyc;
                if (exp_r_q.size() == 0) check("unexpected_echo_rise", 1, 0);
                else check("echo_rise_cycle", cyc, exp_r_q.pop_front());
            end else if (!echo && in_pulse) begin
                in_pulse = 1'b0;
                if (exp_w_q.size() == 0) check("unexpected_echo_width", cyc - rise_c, 0);
                else check("echo_width", cyc - rise_c, exp_w_q.pop_front());
                exp_busy_q.push_back(cyc + HOLD);
            end
            if (trig_err) begin
                if (exp_err_q.size() == 0) check("unexpected_trig_err", cyc, 0);
                else check("trig_err_cycle", cyc, exp_err_q.pop_front());
            end
            if (!busy && busy_prev) begin
                if (exp_busy_q.size() == 0) check("unexpected_busy_fall", cyc, 0);
                else check("busy_fall_cycle", cyc, exp_busy_q.pop_front());
            end
            busy_prev = busy;
        end
    end

    // driver tasks
    task automatic pulse(input int d, input int hi, input bit fresh);
        int unsigned e0;
        @(negedge clk);
        distance = 12'(d);
        trig     = 1'b1;
        for (int i = 1; i <= hi; i++) begin
            @(negedge clk);
            if (fresh && i == 2) check("busy_before_trig_high", busy, 0);
            if (fresh && i == 3) check("busy_in_trig_high", busy, 1);
        end
        trig = 1'b0;
        e0   = cyc + 1;
        if (fresh) begin
            if (hi >= MIN_TRG) begin
                lfsr_m = lfsr_step(lfsr_m);
                exp_w_q.push_back(model_width(d, lfsr_m));
                exp_r_q.push_back(e0 + 2 + BURST);
            end else begin
                exp_err_q.push_back(e0 + 2);
                exp_busy_q.push_back(e0 + 2);
            end
        end
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 5000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 5000) check("idle_timeout", 0, 1);
        repeat (3) @(negedge clk);
    endtask

    task automatic wait_echo(input logic v);
        int n = 0;
        while (echo !== v && n < 5000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 5000) check("echo_wait_timeout", echo, v);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst    = 1'b1;
        lfsr_m = 8'hA5;
        @(negedge clk);
        check("reset_echo", echo, 0);
        check("reset_busy", busy, 0);
        check("reset_trig_err", trig_err, 0);
        @(negedge clk);
        rst = 1'b0;
    endtask

    // main sequence
    initial begin
        int dists[3] = '{0, 101, 100};
        rst      = 1'b1;
        trig     = 1'b0;
        distance = '0;
        lfsr_m   = 8'hA5;
        repeat (3) @(negedge clk);
        check("reset_echo", echo, 0);
        check("reset_busy", busy, 0);
        check("reset_trig_err", trig_err, 0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        pulse(25, 10, 1'b1);
        wait_idle();

        pulse(25, 5, 1'b1);
        wait_idle();

        for (int i = 0; i < 3; i++) begin
            pulse(dists[i], 10, 1'b1);
            wait_idle();
        end

        // stray triggers during BURST, ECHO and HOLDOFF
        pulse(30, 10, 1'b1);
        pulse(30, 6, 1'b0);
        wait_echo(1'b1);
        pulse(30, 10, 1'b0);
        wait_echo(1'b0);
        pulse(30, 4, 1'b0);
        wait_idle();

        // trig held high across HOLDOFF must not retrigger
        pulse(40, 10, 1'b1);
        wait_echo(1'b1);
        @(negedge clk);
        trig = 1'b1;
        wait_idle();
        repeat (30) @(negedge clk);
        check("held_trig_stays_idle", busy, 0);
        trig = 1'b0;
        repeat (5) @(negedge clk);
        pulse(40, 10, 1'b1);
        wait_idle();

        // distance change mid-echo
        pulse(25, 10, 1'b1);
        wait_echo(1'b1);
        repeat (5) @(negedge clk);
        distance = 12'd50;
        wait_idle();

        // reset mid-echo, nothing resumes, then a fresh trigger
        pulse(25, 10, 1'b1);
        wait_echo(1'b1);
        repeat (10) @(negedge clk);
        do_reset();
        repeat (200) @(negedge clk);
        check("no_echo_after_reset", echo, 0);
        pulse(10, 10, 1'b1);
        wait_idle();

        // randomized triggers
        for (int i = 0; i < 12; i++) begin
            pulse(int'($urandom_range(0, 110)), int'($urandom_range(3, 12)), 1'b1);
            wait_idle();
        end

        // first trigger after reset (jitter seed path), then no-target
        do_reset();
        repeat (2) @(negedge clk);
        pulse(25, 10, 1'b1);
        wait_idle();
        pulse(0, 10, 1'b1);
        wait_idle();

        repeat (5) @(negedge clk);
        check("queues_drained",
              exp_w_q.size() + exp_r_q.size() + exp_err_q.size() + exp_busy_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
